// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter in front of a single slave bus.
// Grants are registered, held until the owner drops its request, and every
// ownership change passes through one IDLE turnaround cycle.
module bus_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              reset,
  // master 0 (host)
  input  logic              M0_req,
  input  logic              M0_wr,
  input  logic [ADDR_W-1:0] M0_address,
  input  logic [DATA_W-1:0] M0_dout,
  output logic              M0_grant,
  output logic [DATA_W-1:0] M0_din,
  // master 1 (DMAC)
  input  logic              M1_req,
  input  logic              M1_wr,
  input  logic [ADDR_W-1:0] M1_address,
  input  logic [DATA_W-1:0] M1_dout,
  output logic              M1_grant,
  output logic [DATA_W-1:0] M1_din,
  // slave bus
  output logic              S_sel,
  output logic              S_wr,
  output logic [ADDR_W-1:0] S_address,
  output logic [DATA_W-1:0] S_din,
  input  logic [DATA_W-1:0] S_dout,
  output logic              last_owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_owner_q, last_owner_d;

  // State and round-robin pointer registers
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state: arbitrate only from IDLE, hold a grant while its request stays high
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (M0_req && M1_req) begin
          // contention: favour the master that did not own the bus last
          if (last_owner_q) begin
            state_d      = GRANT0;
            last_owner_d = 1'b0;
          end else begin
            state_d      = GRANT1;
            last_owner_d = 1'b1;
          end
        end else if (M0_req) begin
          state_d      = GRANT0;
          last_owner_d = 1'b0;
        end else if (M1_req) begin
          state_d      = GRANT1;
          last_owner_d = 1'b1;
        end
      end
      GRANT0: if (!M0_req) state_d = IDLE;
      GRANT1: if (!M1_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slave bus mux and grant decode, purely from the registered state
  always_comb begin
    M0_grant  = 1'b0;
    M1_grant  = 1'b0;
    S_sel     = 1'b0;
    S_wr      = 1'b0;
    S_address = '0;
    S_din     = '0;
    unique case (state_q)
      GRANT0: begin
        M0_grant  = 1'b1;
        S_sel     = 1'b1;
        S_wr      = M0_wr;
        S_address = M0_address;
        S_din     = M0_dout;
      end
      GRANT1: begin
        M1_grant  = 1'b1;
        S_sel     = 1'b1;
        S_wr      = M1_wr;
        S_address = M1_address;
        S_din     = M1_dout;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; each master qualifies it with its own grant
  assign M0_din     = S_dout;
  assign M1_din     = S_dout;
  assign last_owner = last_owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized
// run compared against an ownership-level reference model.
module tb_bus_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              Clk = 1'b0;
  logic              reset;
  logic              M0_req, M0_wr, M1_req, M1_wr;
  logic [ADDR_W-1:0] M0_address, M1_address, S_address;
  logic [DATA_W-1:0] M0_dout, M1_dout, M0_din, M1_din, S_din, S_dout;
  logic              M0_grant, M1_grant, S_sel, S_wr, last_owner;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .reset(reset),
    .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address), .M0_dout(M0_dout),
    .M0_grant(M0_grant), .M0_din(M0_din),
    .M1_req(M1_req), .M1_wr(M1_wr), .M1_address(M1_address), .M1_dout(M1_dout),
    .M1_grant(M1_grant), .M1_din(M1_din),
    .S_sel(S_sel), .S_wr(S_wr), .S_address(S_address), .S_din(S_din),
    .S_dout(S_dout), .last_owner(last_owner)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    M0_req = 0; M0_wr = 0; M0_address = '0; M0_dout = '0;
    M1_req = 0; M1_wr = 0; M1_address = '0; M1_dout = '0;
    S_dout = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; M0_req = 1; M1_req = 1;
    tick(); tick();
    checks++; if (M0_grant !== 1'b0) begin failures++; $display("FAIL rst_m0_grant got=%b exp=0", M0_grant); end
    checks++; if (M1_grant !== 1'b0) begin failures++; $display("FAIL rst_m1_grant got=%b exp=0", M1_grant); end
    checks++; if (S_sel !== 1'b0) begin failures++; $display("FAIL rst_s_sel got=%b exp=0", S_sel); end
    checks++; if (S_address !== '0 || S_din !== '0 || S_wr !== 1'b0) begin
      failures++; $display("FAIL rst_s_bus got addr=%h din=%h wr=%b exp 0", S_address, S_din, S_wr); end
    checks++; if (last_owner !== 1'b1) begin failures++; $display("FAIL rst_last_owner got=%b exp=1", last_owner); end
    reset = 0;
    tick();
    checks++; if (M0_grant !== 1'b1 || M1_grant !== 1'b0) begin
      failures++; $display("FAIL rst_release_grant got=%b%b exp m0=1 m1=0", M0_grant, M1_grant); end
    checks++; if (last_owner !== 1'b0) begin failures++; $display("FAIL rst_release_owner got=%b exp=0", last_owner); end
    idle_inputs();
    tick();
  endtask

  task automatic test_single_dmac();
    M1_req = 1; M1_wr = 1; M1_address = 8'h14; M1_dout = 32'hA5;
    tick();
    checks++; if (M1_grant !== 1'b1 || M0_grant !== 1'b0) begin
      failures++; $display("FAIL dmac_grant got m0=%b m1=%b exp m0=0 m1=1", M0_grant, M1_grant); end
    checks++; if (S_sel !== 1'b1 || S_wr !== 1'b1) begin
      failures++; $display("FAIL dmac_sel_wr got sel=%b wr=%b exp 1 1", S_sel, S_wr); end
    checks++; if (S_address !== 8'h14) begin failures++; $display("FAIL dmac_addr got=%h exp=14", S_address); end
    checks++; if (S_din !== 32'hA5) begin failures++; $display("FAIL dmac_din got=%h exp=000000a5", S_din); end
    M1_req = 0;
    tick();
    checks++; if (M1_grant !== 1'b0 || S_sel !== 1'b0) begin
      failures++; $display("FAIL dmac_release got grant=%b sel=%b exp 0 0", M1_grant, S_sel); end
    idle_inputs();
  endtask

  task automatic test_contention();
    // make M0 the last owner first
    M0_req = 1; tick(); M0_req = 0; tick();
    checks++; if (last_owner !== 1'b0) begin failures++; $display("FAIL cont_setup_owner got=%b exp=0", last_owner); end
    M0_req = 1; M1_req = 1;
    tick();
    checks++; if (M1_grant !== 1'b1 || M0_grant !== 1'b0) begin
      failures++; $display("FAIL cont_rr got m0=%b m1=%b exp m0=0 m1=1", M0_grant, M1_grant); end
    M1_req = 0;
    tick();
    checks++; if (M0_grant !== 1'b0 || M1_grant !== 1'b0) begin
      failures++; $display("FAIL cont_turnaround got m0=%b m1=%b exp 0 0", M0_grant, M1_grant); end
    tick();
    checks++; if (M0_grant !== 1'b1 || M1_grant !== 1'b0) begin
      failures++; $display("FAIL cont_handover got m0=%b m1=%b exp m0=1 m1=0", M0_grant, M1_grant); end
  endtask

  // Entered with M0 holding the bus
  task automatic test_no_preempt();
    logic [ADDR_W-1:0] a;
    M1_req = 1;
    for (int i = 0; i < 20; i++) begin
      a = ADDR_W'($urandom);
      M0_address = a;
      tick();
      checks++;
      if (M0_grant !== 1'b1 || M1_grant !== 1'b0 || S_address !== a) begin
        failures++;
        $display("FAIL no_preempt cyc=%0d got m0=%b m1=%b addr=%h exp m0=1 m1=0 addr=%h",
                 i, M0_grant, M1_grant, S_address, a);
      end
    end
  endtask

  // Entered with M0 holding the bus
  task automatic test_read_path();
    M0_wr = 0; M1_wr = 1; S_dout = 32'h0000000A;
    #1;
    checks++; if (S_wr !== 1'b0) begin failures++; $display("FAIL read_s_wr got=%b exp=0", S_wr); end
    checks++; if (M0_din !== 32'h0000000A || M1_din !== 32'h0000000A) begin
      failures++; $display("FAIL read_din got m0=%h m1=%h exp 0000000a", M0_din, M1_din); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    M1_req = 1; tick();
    checks++; if (M1_grant !== 1'b1) begin failures++; $display("FAIL midrst_setup got=%b exp=1", M1_grant); end
    M0_req = 1; reset = 1;
    tick();
    checks++; if (M1_grant !== 1'b0 || M0_grant !== 1'b0) begin
      failures++; $display("FAIL midrst_drop got m0=%b m1=%b exp 0 0", M0_grant, M1_grant); end
    checks++; if (last_owner !== 1'b1) begin failures++; $display("FAIL midrst_owner got=%b exp=1", last_owner); end
    reset = 0;
    tick();
    checks++; if (M0_grant !== 1'b1 || M1_grant !== 1'b0) begin
      failures++; $display("FAIL midrst_after got m0=%b m1=%b exp m0=1 m1=0", M0_grant, M1_grant); end
    idle_inputs();
    tick();
  endtask

  // Reference: owner is -1 (bus free), 0 or 1; rr is the last owner index
  task automatic test_random();
    int owner;
    int rr;
    int r0, r1, rst;
    logic              e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_din;
    owner = -1; rr = 1;
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 600; i++) begin
      r0  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      r1  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      rst = ($urandom_range(0, 49) == 0) ? 1 : 0;
      M0_req = r0[0]; M1_req = r1[0]; reset = rst[0];
      M0_wr = 1'($urandom); M1_wr = 1'($urandom);
      M0_address = ADDR_W'($urandom); M1_address = ADDR_W'($urandom);
      M0_dout = $urandom; M1_dout = $urandom; S_dout = $urandom;
      if (rst == 1) begin
        owner = -1; rr = 1;
      end else if (owner == -1) begin
        if (r0 == 1 && r1 == 1) owner = 1 - rr;
        else if (r0 == 1) owner = 0;
        else if (r1 == 1) owner = 1;
        if (owner != -1) rr = owner;
      end else if ((owner == 0 && r0 == 0) || (owner == 1 && r1 == 0)) begin
        owner = -1;
      end
      tick();
      e_wr   = (owner == 0) ? M0_wr : (owner == 1) ? M1_wr : 1'b0;
      e_addr = (owner == 0) ? M0_address : (owner == 1) ? M1_address : '0;
      e_din  = (owner == 0) ? M0_dout : (owner == 1) ? M1_dout : '0;
      checks++;
      if (M0_grant !== (owner == 0) || M1_grant !== (owner == 1) || S_sel !== (owner != -1) ||
          last_owner !== rr[0]) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d got m0=%b m1=%b sel=%b lo=%b exp owner=%0d lo=%0d",
                 i, M0_grant, M1_grant, S_sel, last_owner, owner, rr);
      end
      checks++;
      if (S_wr !== e_wr || S_address !== e_addr || S_din !== e_din ||
          M0_din !== S_dout || M1_din !== S_dout) begin
        failures++;
        $display("FAIL rand_bus cyc=%0d got wr=%b addr=%h din=%h exp wr=%b addr=%h din=%h",
                 i, S_wr, S_address, S_din, e_wr, e_addr, e_din);
      end
    end
    reset = 0;
    idle_inputs();
    tick();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_dmac();
    test_contention();
    test_no_preempt();
    test_read_path();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
